// File: rtl/crc_stream_checker_pkg.sv
// Shared types and constants for the framed CRC stream checker.
// Defaults describe the CRC-32/MPEG-2 flavour (no reflection, no final XOR).
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRCFLD
    } state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOR  = 32'h00000000;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CRC_W   = 32;
    localparam int FIELD_WORDS = DEF_CRC_W / DEF_DATA_W;

    function automatic int field_words(input int crc_w, input int data_w);
        return crc_w / data_w;
    endfunction

endpackage

// File: rtl/crc_stream_checker_crc_next.sv
// Combinational CRC update: folds one DATA_W word into the register, MSB first,
// in normal (non-reflected) polynomial form.
module crc_next #(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 32,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(32'h04C11DB7)
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] c;

    always_comb begin
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (c[CRC_W-1] ^ data[i]) begin
                c = (c << 1) ^ POLY;
            end else begin
                c = c << 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_stream_checker.sv
// Framed-stream CRC checker: hashes payload words, captures and forwards the
// received CRC field, and reports pass/fail plus length/ordering errors per frame.
module crc_stream_checker
    import crc_pkg::*;
#(
    parameter int               DATA_W  = 8,
    parameter int               CRC_W   = 32,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC32_POLY),
    parameter logic [CRC_W-1:0] INIT    = CRC_W'(CRC32_INIT),
    parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(CRC32_XOR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_crc,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic              crc_ok,
    output logic              len_err,
    output logic              order_err,
    output logic [CRC_W-1:0]  crc_calc
);

    localparam int FW    = field_words(CRC_W, DATA_W);
    localparam int CNT_W = $clog2(FW + 2);
    localparam logic [CNT_W-1:0] FW_C   = CNT_W'(FW);
    localparam logic [CNT_W-1:0] FW_SAT = CNT_W'(FW + 1);

    state_t           state_q;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] cap_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ord_q;

    logic             is_pay;
    logic             is_fld;
    logic             is_bad;
    logic [CRC_W-1:0] crc_hashed;
    logic [CRC_W-1:0] crc_nxt;
    logic [CRC_W-1:0] cap_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ord_nxt;
    logic [CRC_W-1:0] calc_fin;

    crc_next #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_crc_next (
        .crc_in  (crc_q),
        .data    (in_data),
        .crc_out (crc_hashed)
    );

    // Next-state view of the frame accumulators, so the in_last beat itself
    // contributes to the reported result.
    always_comb begin
        is_pay  = in_valid && !in_crc && (state_q != CRCFLD);
        is_fld  = in_valid && in_crc;
        is_bad  = in_valid && !in_crc && (state_q == CRCFLD);
        crc_nxt = is_pay ? crc_hashed : crc_q;
        cap_nxt = cap_q;
        if (is_fld && (cnt_q < FW_C)) begin
            cap_nxt = (cap_q << DATA_W) | CRC_W'(in_data);
        end
        cnt_nxt = cnt_q;
        if (is_fld && (cnt_q != FW_SAT)) begin
            cnt_nxt = cnt_q + 1'b1;
        end
        ord_nxt  = ord_q | is_bad;
        calc_fin = crc_nxt ^ XOR_OUT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            cap_q     <= '0;
            cnt_q     <= '0;
            ord_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            len_err   <= 1'b0;
            order_err <= 1'b0;
            crc_calc  <= '0;
        end else begin
            out_valid <= is_fld;
            out_data  <= is_fld ? in_data : '0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            len_err   <= 1'b0;
            order_err <= 1'b0;
            if (in_valid) begin
                if (in_last) begin
                    state_q   <= IDLE;
                    crc_q     <= INIT;
                    cap_q     <= '0;
                    cnt_q     <= '0;
                    ord_q     <= 1'b0;
                    done      <= 1'b1;
                    crc_ok    <= (calc_fin == cap_nxt) && (cnt_nxt == FW_C) && !ord_nxt;
                    len_err   <= (cnt_nxt != FW_C);
                    order_err <= ord_nxt || (cnt_nxt == '0);
                    crc_calc  <= calc_fin;
                end else begin
                    crc_q <= crc_nxt;
                    cap_q <= cap_nxt;
                    cnt_q <= cnt_nxt;
                    ord_q <= ord_nxt;
                    unique case (state_q)
                        IDLE:    state_q <= in_crc ? CRCFLD : PAYLOAD;
                        PAYLOAD: if (in_crc) state_q <= CRCFLD;
                        CRCFLD:  state_q <= CRCFLD;
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_checker.sv
// Directed bench for crc_stream_checker using the CRC-32/MPEG-2 check string "123456789".
module tb_crc_stream_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_crc;
    logic        in_last;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        done;
    logic        crc_ok;
    logic        len_err;
    logic        order_err;
    logic [31:0] crc_calc;

    int tests  = 0;
    int failed = 0;

    logic [7:0] msg  [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [7:0] crcb [4] = '{8'h03, 8'h76, 8'hE6, 8'hE7};

    crc_stream_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_crc    (in_crc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_data  (out_data),
        .done      (done),
        .crc_ok    (crc_ok),
        .len_err   (len_err),
        .order_err (order_err),
        .crc_calc  (crc_calc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One valid beat; outputs are checked #1 after the edge that consumes it.
    task automatic send(input logic [7:0] d, input logic c, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_crc   = c;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("out_valid", {31'b0, out_valid}, {31'b0, c});
        check("out_data", {24'b0, out_data}, c ? {24'b0, d} : 32'h0);
        check("done", {31'b0, done}, {31'b0, l});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_crc   = 1'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
            #1;
            check("idle_out_valid", {31'b0, out_valid}, 32'h0);
            check("idle_done", {31'b0, done}, 32'h0);
            check("idle_crc_ok", {31'b0, crc_ok}, 32'h0);
        end
    endtask

    task automatic check_res(input logic ok, input logic len, input logic ord,
                             input logic chk_calc, input logic [31:0] calc);
        check("res_done", {31'b0, done}, 32'h1);
        check("res_crc_ok", {31'b0, crc_ok}, {31'b0, ok});
        check("res_len_err", {31'b0, len_err}, {31'b0, len});
        check("res_order_err", {31'b0, order_err}, {31'b0, ord});
        if (chk_calc) check("res_crc_calc", crc_calc, calc);
    endtask

    task automatic run_frame(input int ncrc, input logic [7:0] last_crc, input int max_gap);
        for (int i = 0; i < 9; i++) begin
            send(msg[i], 1'b0, 1'b0);
            if (max_gap > 0) idle($urandom_range(1, max_gap));
        end
        for (int i = 0; i < ncrc; i++) begin
            send((i == 3) ? last_crc : crcb[i], 1'b1, (i == ncrc - 1));
            if (max_gap > 0 && i < ncrc - 1) idle($urandom_range(1, max_gap));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_crc   = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_crc_calc", crc_calc, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Good frame
        run_frame(4, 8'hE7, 0);
        check_res(1'b1, 1'b0, 1'b0, 1'b1, 32'h0376E6E7);
        idle(1);

        // Corrupted last CRC byte
        run_frame(4, 8'hE6, 0);
        check_res(1'b0, 1'b0, 1'b0, 1'b1, 32'h0376E6E7);
        idle(1);

        // Short CRC field
        run_frame(3, 8'h00, 0);
        check_res(1'b0, 1'b1, 1'b0, 1'b1, 32'h0376E6E7);
        idle(1);

        // Payload after CRC beat; five field beats in total
        send(8'h31, 1'b0, 1'b0);
        send(8'h32, 1'b0, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        send(8'h76, 1'b1, 1'b0);
        send(8'hE6, 1'b1, 1'b0);
        send(8'hE7, 1'b1, 1'b1);
        check_res(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        idle(1);

        // Gapped stream
        run_frame(4, 8'hE7, 3);
        check_res(1'b1, 1'b0, 1'b0, 1'b1, 32'h0376E6E7);

        // Back-to-back: second frame begins on the done cycle
        run_frame(4, 8'hE7, 0);
        check_res(1'b1, 1'b0, 1'b0, 1'b1, 32'h0376E6E7);
        idle(1);

        // Single-beat frames: empty payload, and payload-only
        send(8'h03, 1'b1, 1'b1);
        check_res(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF);
        send(8'h31, 1'b0, 1'b1);
        check_res(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        idle(1);

        // Reset mid-frame, then a clean frame
        for (int i = 0; i < 5; i++) send(msg[i], 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_crc_calc", crc_calc, 32'h0);
        @(posedge clk);
        #1;
        check("midrst_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        run_frame(4, 8'hE7, 0);
        check_res(1'b1, 1'b0, 1'b0, 1'b1, 32'h0376E6E7);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/crc_stream_checker.md
Name: crc_stream_checker

Overview:
- Parametrised successor to the single-bit CRC gate.
- Accepts a framed word stream in which payload words are followed by a received CRC field.
- Computes the CRC over the payload, captures the received CRC words and forwards them on a gated output.
- At frame end, reports pass/fail plus field-length and ordering errors; sits between the deframer and the packet-status logic.

Parameters:
- DATA_W, 8, input word width in bits; CRC_W must be an integer multiple of DATA_W.
- CRC_W, 32, CRC width in bits.
- POLY, 32'h04C11DB7, generator polynomial, normal (MSB-first) form, no reflection.
- INIT, 32'hFFFFFFFF, CRC register value at frame start.
- XOR_OUT, 32'h00000000, final XOR applied to the computed CRC before comparison.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last/in_crc are valid this cycle; no backpressure, every valid beat is consumed.
- in_data  input  DATA_W  data word; MSB is processed first.
- in_crc  input  1  beat belongs to the received CRC field (0 = payload).
- in_last  input  1  final beat of the frame.
- out_valid  output  1  out_data carries a forwarded CRC-field word.
- out_data  output  DATA_W  forwarded CRC word; zero whenever out_valid=0.
- done  output  1  one-cycle pulse: frame result valid.
- crc_ok  output  1  result, sampled with done.
- len_err  output  1  CRC field word count is not CRC_W/DATA_W; sampled with done.
- order_err  output  1  payload beat after a CRC beat, or a frame with no CRC beats; sampled with done.
- crc_calc  output  CRC_W  final computed CRC (XOR_OUT applied); held until the next done.

Behaviour:
- Reset (async assert, release synchronous to clk): state=IDLE; crc register=INIT; all outputs 0, including crc_calc.
- States:
  - IDLE: waiting for first beat.
  - PAYLOAD: accumulating payload.
  - CRCFLD: capturing the CRC field.
- Transitions:
  - IDLE, valid beat with in_crc=0 -> PAYLOAD.
  - IDLE, valid beat with in_crc=1 -> CRCFLD (empty payload is legal; CRC=INIT^XOR_OUT).
  - PAYLOAD, in_crc=1 -> CRCFLD.
  - CRCFLD, in_crc=0 -> sets sticky order_err flag and stays in CRCFLD; the beat is neither hashed nor captured.
  - Any state, valid beat with in_last=1 -> IDLE after the beat is processed.
- Payload beats update the CRC register by DATA_W serial steps, MSB first, in a single cycle.
- CRC-field beats shift into a CRC_W-bit capture register (left shift, new word in LSBs).
  - The field word counter saturates at CRC_W/DATA_W+1.
  - Words beyond CRC_W/DATA_W are still forwarded but not captured.
- Forwarding: a valid in_crc=1 beat gives out_valid=1 and out_data=in_data on the next cycle (1-cycle latency). Otherwise out_valid=0 and out_data=0.
- Result: done=1 on the cycle after the in_last beat, all result flags valid that cycle.
  - crc_ok=1 only if: computed CRC == captured field, count == CRC_W/DATA_W, and no order_err.
  - crc_ok, len_err and order_err are 0 whenever done=0.
- Single-beat frame (in_last on the first beat):
  - If that beat has in_crc=1: count=1, so len_err=1 unless CRC_W==DATA_W.
  - If it has in_crc=0: no CRC beats, so order_err=1.
- A new frame may start on the cycle done is high; the CRC register is reloaded with INIT on the in_last beat.
- in_valid=0 cycles inside a frame: all state holds.
- in_crc, in_last and in_data are ignored when in_valid=0.
- Reset mid-frame: the frame is abandoned and done is not raised.

Decomposition:
- Shared package crc_pkg holds:
  - the state enum (IDLE, PAYLOAD, CRCFLD);
  - CRC32_POLY, CRC32_INIT and CRC32_XOR constants;
  - a helper constant FIELD_WORDS = CRC_W/DATA_W.
- One sub-module: crc_next, purely combinational: (crc_in, data) -> crc_out, parametrised by DATA_W, CRC_W and POLY.

Test Plan:
- Payload ASCII "123456789" (9 beats, DATA_W=8), then CRC beats 03,76,E6,E7 with in_last on E7 -> out_data 03,76,E6,E7 each 1 cycle late; done=1, crc_ok=1, crc_calc=32'h0376E6E7.
- Same frame with last CRC beat E6 -> done=1, crc_ok=0, len_err=0, order_err=0, crc_calc=32'h0376E6E7.
- Same payload, only 3 CRC beats (03,76,E6), in_last on the 3rd -> len_err=1, crc_ok=0.
- Payload "12", CRC beat, payload "3", then 4 CRC beats -> order_err=1, crc_ok=0.
- Valid frame with in_valid=0 gaps of 1-3 cycles between every beat -> identical result to scenario 1.
- Back-to-back: a second valid frame starts on the done cycle -> both frames report crc_ok=1.
- Assert reset after 5 payload beats, then send the full scenario-1 frame -> no done during reset; scenario-1 result on the new frame.
